// File: rtl/tbird_lights_decoder.sv
// tbird_lights_decoder: receive-side checker for the taillight lamp buses.
// It tracks left/right sweeps and hazard frames, counts completions and flags protocol errors.
module tbird_lights_decoder #(
    parameter int CNT_W    = 8,
    parameter int HOLD_MAX = 0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             sample_en,
    input  logic [2:0]       l_lights,
    input  logic [2:0]       r_lights,
    input  logic             clr_cnt,
    output logic             left_done,
    output logic             right_done,
    output logic             haz_done,
    output logic             seq_abort,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             busy,
    output logic [CNT_W-1:0] left_cnt,
    output logic [CNT_W-1:0] right_cnt,
    output logic [CNT_W-1:0] haz_cnt
);

    localparam int HW = $clog2(HOLD_MAX + 2);

    typedef enum logic [3:0] {
        S_OFF, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_BOTH, S_RESYNC
    } state_t;

    state_t        state;
    state_t        pat;
    logic          legal;
    logic          repeat_hit;
    logic          hold_ok;
    logic          abort;
    logic          l_fin;
    logic          r_fin;
    logic          h_fin;
    logic [HW-1:0] hold_cnt;

    // Map the sampled lamp pair onto the state it would represent; S_RESYNC marks an illegal pattern.
    always_comb begin
        case ({l_lights, r_lights})
            6'o00:   pat = S_OFF;
            6'o10:   pat = S_L1;
            6'o30:   pat = S_L2;
            6'o70:   pat = S_L3;
            6'o01:   pat = S_R1;
            6'o03:   pat = S_R2;
            6'o07:   pat = S_R3;
            6'o77:   pat = S_BOTH;
            default: pat = S_RESYNC;
        endcase
    end

    // Allowed moves out of each state to a different (legal) pattern.
    always_comb begin
        case (state)
            S_OFF:   legal = pat inside {S_OFF, S_L1, S_R1, S_BOTH};
            S_L1:    legal = pat inside {S_L2, S_BOTH};
            S_L2:    legal = pat inside {S_L3, S_BOTH};
            S_L3:    legal = pat == S_OFF;
            S_R1:    legal = pat inside {S_R2, S_BOTH};
            S_R2:    legal = pat inside {S_R3, S_BOTH};
            S_R3:    legal = pat == S_OFF;
            S_BOTH:  legal = pat == S_OFF;
            default: legal = 1'b0;
        endcase
    end

    assign repeat_hit = (pat == state) && (state != S_OFF);
    assign hold_ok    = int'(hold_cnt) + 1 <= HOLD_MAX;
    assign abort      = (pat == S_BOTH) && (state inside {S_L1, S_L2, S_R1, S_R2});
    assign l_fin      = sample_en && (state == S_L3) && (pat == S_OFF);
    assign r_fin      = sample_en && (state == S_R3) && (pat == S_OFF);
    assign h_fin      = sample_en && (state == S_BOTH) && (pat == S_OFF);
    assign busy       = state != S_OFF;

    // Sequence tracking, error detection and registered pulses.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state      <= S_OFF;
            hold_cnt   <= '0;
            left_done  <= 1'b0;
            right_done <= 1'b0;
            haz_done   <= 1'b0;
            seq_abort  <= 1'b0;
            err        <= 1'b0;
            err_code   <= 2'b00;
        end else begin
            left_done  <= 1'b0;
            right_done <= 1'b0;
            haz_done   <= 1'b0;
            seq_abort  <= 1'b0;
            err        <= 1'b0;
            if (sample_en) begin
                if (state == S_RESYNC) begin
                    if (pat == S_OFF) state <= S_OFF;
                end else if (pat == S_RESYNC) begin
                    err      <= 1'b1;
                    err_code <= 2'b01;
                    state    <= S_RESYNC;
                    hold_cnt <= '0;
                end else if (repeat_hit) begin
                    if (hold_ok) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        err      <= 1'b1;
                        err_code <= 2'b11;
                        state    <= S_RESYNC;
                        hold_cnt <= '0;
                    end
                end else if (legal) begin
                    state      <= pat;
                    hold_cnt   <= '0;
                    left_done  <= l_fin;
                    right_done <= r_fin;
                    haz_done   <= h_fin;
                    seq_abort  <= abort;
                end else begin
                    err      <= 1'b1;
                    err_code <= 2'b10;
                    state    <= S_RESYNC;
                    hold_cnt <= '0;
                end
            end
        end
    end

    // Saturating completion counters; a clear beats a coincident increment.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            left_cnt  <= '0;
            right_cnt <= '0;
            haz_cnt   <= '0;
        end else if (clr_cnt) begin
            left_cnt  <= '0;
            right_cnt <= '0;
            haz_cnt   <= '0;
        end else begin
            if (l_fin && left_cnt != '1) left_cnt <= left_cnt + CNT_W'(1);
            if (r_fin && right_cnt != '1) right_cnt <= right_cnt + CNT_W'(1);
            if (h_fin && haz_cnt != '1) haz_cnt <= haz_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tbird_lights_decoder.sv
// tb_tbird_lights_decoder: two decoder instances (HOLD_MAX=1/CNT_W=2 and HOLD_MAX=0/CNT_W=8) checked against a pattern-level model.
module tb_tbird_lights_decoder;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       sample_en;
    logic [2:0] l_lights;
    logic [2:0] r_lights;
    logic       clr_cnt;

    logic       a_ld, a_rd, a_hd, a_ab, a_er, a_busy;
    logic [1:0] a_code, a_lc, a_rc, a_hc;
    logic       b_ld, b_rd, b_hd, b_ab, b_er, b_busy;
    logic [1:0] b_code;
    logic [7:0] b_lc, b_rc, b_hc;

    int vecs  = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tbird_lights_decoder #(.CNT_W(2), .HOLD_MAX(1)) dut_a (
        .clk(clk), .rst_b(rst_b), .sample_en(sample_en), .l_lights(l_lights), .r_lights(r_lights),
        .clr_cnt(clr_cnt), .left_done(a_ld), .right_done(a_rd), .haz_done(a_hd), .seq_abort(a_ab),
        .err(a_er), .err_code(a_code), .busy(a_busy), .left_cnt(a_lc), .right_cnt(a_rc), .haz_cnt(a_hc)
    );

    tbird_lights_decoder #(.CNT_W(8), .HOLD_MAX(0)) dut_b (
        .clk(clk), .rst_b(rst_b), .sample_en(sample_en), .l_lights(l_lights), .r_lights(r_lights),
        .clr_cnt(clr_cnt), .left_done(b_ld), .right_done(b_rd), .haz_done(b_hd), .seq_abort(b_ab),
        .err(b_er), .err_code(b_code), .busy(b_busy), .left_cnt(b_lc), .right_cnt(b_rc), .haz_cnt(b_hc)
    );

    // Model state: last accepted {l,r} pattern, resync flag, hold count, counts and expected outputs.
    typedef struct {
        logic [5:0] last;
        bit         rs;
        int         hold;
        int         lc, rc, hc;
        bit         ld, rd, hd, ab, er;
        logic [1:0] code;
    } mdl_t;

    mdl_t ma, mb;

    logic [13:0] obs_a, exp_a;
    logic [31:0] obs_b, exp_b;

    assign obs_a = {a_ld, a_rd, a_hd, a_ab, a_er, a_code, a_busy, a_lc, a_rc, a_hc};
    assign obs_b = {b_ld, b_rd, b_hd, b_ab, b_er, b_code, b_busy, b_lc, b_rc, b_hc};

    always_comb begin
        exp_a = {ma.ld, ma.rd, ma.hd, ma.ab, ma.er, ma.code, ma.rs || ma.last != 6'o00,
                 ma.lc[1:0], ma.rc[1:0], ma.hc[1:0]};
        exp_b = {mb.ld, mb.rd, mb.hd, mb.ab, mb.er, mb.code, mb.rs || mb.last != 6'o00,
                 mb.lc[7:0], mb.rc[7:0], mb.hc[7:0]};
    end

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.last = 6'o00; m.rs = 0; m.hold = 0; m.lc = 0; m.rc = 0; m.hc = 0;
        m.ld = 0; m.rd = 0; m.hd = 0; m.ab = 0; m.er = 0; m.code = 2'b00;
        return m;
    endfunction

    function automatic bit is_legal(logic [5:0] p);
        return p inside {6'o00, 6'o10, 6'o30, 6'o70, 6'o01, 6'o03, 6'o07, 6'o77};
    endfunction

    // A sweep lights one more inner-to-outer lamp per step (thermometer code), then goes dark.
    function automatic bit may_follow(logic [5:0] a, logic [5:0] b);
        logic [2:0] v, nv;
        if (a == 6'o00) return b inside {6'o00, 6'o10, 6'o01, 6'o77};
        if (a == 6'o77) return b == 6'o00;
        v  = a[5:3] | a[2:0];
        nv = 3'((v << 1) | 3'd1);
        if (v == 3'd7) return b == 6'o00;
        return b == 6'o77 || b == (a[5:3] != 3'd0 ? {nv, 3'd0} : {3'd0, nv});
    endfunction

    function automatic mdl_t step(mdl_t m, bit s, logic [5:0] p, bit c, int hmax, int cmax);
        mdl_t n = m;
        n.ld = 0; n.rd = 0; n.hd = 0; n.ab = 0; n.er = 0;
        if (s) begin
            if (m.rs) begin
                if (p == 6'o00) begin n.rs = 0; n.last = 6'o00; end
            end else if (!is_legal(p)) begin
                n.er = 1; n.code = 2'b01;
            end else if (p == m.last && p != 6'o00) begin
                if (m.hold < hmax) n.hold = m.hold + 1;
                else begin n.er = 1; n.code = 2'b11; end
            end else if (may_follow(m.last, p)) begin
                n.last = p; n.hold = 0;
                n.ld = m.last == 6'o70 && p == 6'o00;
                n.rd = m.last == 6'o07 && p == 6'o00;
                n.hd = m.last == 6'o77 && p == 6'o00;
                n.ab = p == 6'o77 && m.last != 6'o00;
            end else begin
                n.er = 1; n.code = 2'b10;
            end
            if (n.er) begin n.rs = 1; n.hold = 0; end
        end
        n.lc = c ? 0 : (m.lc + int'(n.ld) > cmax ? cmax : m.lc + int'(n.ld));
        n.rc = c ? 0 : (m.rc + int'(n.rd) > cmax ? cmax : m.rc + int'(n.rd));
        n.hc = c ? 0 : (m.hc + int'(n.hd) > cmax ? cmax : m.hc + int'(n.hd));
        return n;
    endfunction

    task automatic apply(input bit s, input logic [5:0] p, input bit c);
        sample_en = s;
        {l_lights, r_lights} = p;
        clr_cnt = c;
        @(posedge clk);
        ma = step(ma, s, p, c, 1, 3);
        mb = step(mb, s, p, c, 0, 255);
        #1;
    endtask

    task automatic test_reset();
        rst_b = 1'b0; sample_en = 1'b0; l_lights = 3'd0; r_lights = 3'd0; clr_cnt = 1'b0;
        ma = mdl_reset(); mb = mdl_reset();
        repeat (2) @(posedge clk);
        #1;
        vecs++;
        if (obs_a !== 14'd0 || obs_b !== 32'd0) begin
            fails++; $display("FAIL reset: a=%h b=%h want 0", obs_a, obs_b);
        end
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    task automatic test_left_sweep();
        logic [5:0] seq[5] = '{6'o00, 6'o10, 6'o30, 6'o70, 6'o00};
        int busy_cycles = 0;
        foreach (seq[i]) begin
            apply(1, seq[i], 0);
            busy_cycles += int'(a_busy);
            vecs++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                fails++; $display("FAIL left_sweep[%0d]: a=%h want %h b=%h want %h", i, obs_a, exp_a, obs_b, exp_b);
            end
        end
        vecs++;
        if (a_ld !== 1'b1 || a_lc !== 2'd1 || b_lc !== 8'd1 || busy_cycles != 3) begin
            fails++; $display("FAIL left_done: ld=%b lc=%0d/%0d busy=%0d want 1 1/1 3", a_ld, a_lc, b_lc, busy_cycles);
        end
    endtask

    task automatic test_hazard_preempt();
        logic [5:0] seq[5] = '{6'o00, 6'o01, 6'o03, 6'o77, 6'o00};
        foreach (seq[i]) begin
            apply(1, seq[i], 0);
            vecs++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                fails++; $display("FAIL hazard[%0d]: a=%h want %h b=%h want %h", i, obs_a, exp_a, obs_b, exp_b);
            end
            if (i == 3) begin
                vecs++;
                if (a_ab !== 1'b1 || b_ab !== 1'b1) begin
                    fails++; $display("FAIL seq_abort: a=%b b=%b want 1", a_ab, b_ab);
                end
            end
        end
        vecs++;
        if (a_hd !== 1'b1 || a_hc !== 2'd1 || a_rc !== 2'd0) begin
            fails++; $display("FAIL haz_done: hd=%b hc=%0d rc=%0d want 1 1 0", a_hd, a_hc, a_rc);
        end
    endtask

    task automatic test_illegal_pattern();
        logic [5:0] seq[8] = '{6'o00, 6'o20, 6'o30, 6'o00, 6'o10, 6'o30, 6'o70, 6'o00};
        foreach (seq[i]) begin
            apply(1, seq[i], 0);
            vecs++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                fails++; $display("FAIL illegal[%0d]: a=%h want %h b=%h want %h", i, obs_a, exp_a, obs_b, exp_b);
            end
            if (i == 1) begin
                vecs++;
                if (a_er !== 1'b1 || a_code !== 2'b01 || a_busy !== 1'b1) begin
                    fails++; $display("FAIL illegal_err: err=%b code=%b busy=%b want 1 01 1", a_er, a_code, a_busy);
                end
            end
        end
        vecs++;
        if (a_ld !== 1'b1 || b_ld !== 1'b1) begin
            fails++; $display("FAIL illegal_recover: ld a=%b b=%b want 1", a_ld, b_ld);
        end
    endtask

    task automatic test_hold();
        logic [5:0] seq[7] = '{6'o00, 6'o10, 6'o10, 6'o30, 6'o30, 6'o30, 6'o00};
        logic [6:0] errs_a = '0, errs_b = '0;
        foreach (seq[i]) begin
            apply(1, seq[i], 0);
            errs_a[i] = a_er;
            errs_b[i] = b_er;
            vecs++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                fails++; $display("FAIL hold[%0d]: a=%h want %h b=%h want %h", i, obs_a, exp_a, obs_b, exp_b);
            end
        end
        vecs++;
        if (errs_a !== 7'b0100000 || errs_b !== 7'b0000100 || a_code !== 2'b11 || b_code !== 2'b11) begin
            fails++; $display("FAIL hold_err: a=%b/%b b=%b/%b want 0100000/11 0000100/11", errs_a, a_code, errs_b, b_code);
        end
    endtask

    task automatic test_illegal_transition();
        logic [5:0] seq[4] = '{6'o00, 6'o10, 6'o70, 6'o00};
        logic [5:0] tail[3] = '{6'o30, 6'o70, 6'o00};
        foreach (seq[i]) begin
            apply(1, seq[i], 0);
            vecs++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                fails++; $display("FAIL trans[%0d]: a=%h want %h b=%h want %h", i, obs_a, exp_a, obs_b, exp_b);
            end
            if (i == 2) begin
                vecs++;
                if (a_er !== 1'b1 || a_code !== 2'b10) begin
                    fails++; $display("FAIL trans_err: err=%b code=%b want 1 10", a_er, a_code);
                end
            end
        end
        apply(1, 6'o10, 0);
        for (int i = 0; i < 5; i++) begin
            apply(0, 6'($urandom), 0);
            vecs++;
            if (obs_a !== exp_a || obs_b !== exp_b || a_er !== 1'b0) begin
                fails++; $display("FAIL gap[%0d]: a=%h want %h b=%h want %h", i, obs_a, exp_a, obs_b, exp_b);
            end
        end
        foreach (tail[i]) apply(1, tail[i], 0);
        vecs++;
        if (a_ld !== 1'b1 || b_ld !== 1'b1 || a_er !== 1'b0) begin
            fails++; $display("FAIL gap_done: ld a=%b b=%b err=%b want 1 1 0", a_ld, b_ld, a_er);
        end
    endtask

    task automatic test_saturation_clear();
        logic [5:0] sw[4] = '{6'o10, 6'o30, 6'o70, 6'o00};
        apply(1, 6'o00, 1);
        for (int k = 0; k < 5; k++) foreach (sw[i]) apply(1, sw[i], 0);
        vecs++;
        if (a_lc !== 2'd3 || b_lc !== 8'd5 || obs_a !== exp_a) begin
            fails++; $display("FAIL saturate: lc a=%0d b=%0d want 3 5", a_lc, b_lc);
        end
        foreach (sw[i]) apply(1, sw[i], i == 3);
        vecs++;
        if (a_lc !== 2'd0 || b_lc !== 8'd0 || a_ld !== 1'b1 || obs_b !== exp_b) begin
            fails++; $display("FAIL clear_wins: lc a=%0d b=%0d ld=%b want 0 0 1", a_lc, b_lc, a_ld);
        end
    endtask

    task automatic test_reset_mid();
        apply(1, 6'o00, 0);
        apply(1, 6'o10, 0);
        apply(1, 6'o30, 0);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        ma = mdl_reset(); mb = mdl_reset();
        vecs++;
        if (obs_a !== 14'd0 || obs_b !== 32'd0) begin
            fails++; $display("FAIL reset_mid: a=%h b=%h want 0", obs_a, obs_b);
        end
        @(negedge clk);
        rst_b = 1'b1;
        apply(1, 6'o70, 0);
        vecs++;
        if (obs_a !== exp_a || obs_b !== exp_b || a_code !== 2'b10) begin
            fails++; $display("FAIL after_reset: a=%h want %h b=%h want %h", obs_a, exp_a, obs_b, exp_b);
        end
        apply(1, 6'o00, 0);
    endtask

    task automatic test_random();
        logic [5:0] pats[8] = '{6'o00, 6'o10, 6'o30, 6'o70, 6'o01, 6'o03, 6'o07, 6'o77};
        for (int i = 0; i < 600; i++) begin
            logic [5:0] cand[$];
            logic [5:0] p;
            foreach (pats[j])
                if (ma.rs ? pats[j] == 6'o00
                          : (may_follow(ma.last, pats[j]) || (pats[j] == ma.last && pats[j] != 6'o00)))
                    cand.push_back(pats[j]);
            p = ($urandom_range(0, 9) < 8) ? cand[$urandom_range(0, cand.size() - 1)] : 6'($urandom);
            apply($urandom_range(0, 7) != 0, p, $urandom_range(0, 40) == 0);
            vecs++;
            if (obs_a !== exp_a || obs_b !== exp_b) begin
                fails++; $display("FAIL random[%0d]: a=%h want %h b=%h want %h", i, obs_a, exp_a, obs_b, exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_left_sweep();
        test_hazard_preempt();
        test_illegal_pattern();
        test_hold();
        test_illegal_transition();
        test_saturation_clear();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/tbird_lights_decoder.md
Name: tbird_lights_decoder

Overview:
- Receive-side checker for the taillight interface; watches the 3-bit left and right lamp buses each sampled cycle.
- Tracks the sweep sequence and reports completed left, right and hazard sequences as pulses and saturating counts.
- Flags illegal lamp patterns, illegal transitions and stuck patterns, then resynchronises on the next all-off frame.
- Sits beside the lamp driver in testbench harnesses and in the dashboard status path.

Parameters:
- CNT_W, 8, width of each saturating sequence counter.
- HOLD_MAX, 0, extra consecutive samples a non-OFF pattern may repeat before a hold error (0 = must advance every sample).

Ports:
- clk  in  1  clock
- rst_b  in  1  asynchronous active-low reset
- sample_en  in  1  lamp buses valid this cycle; low = ignore the cycle
- l_lights  in  3  left lamp bus, bit0 innermost
- r_lights  in  3  right lamp bus, bit0 innermost
- clr_cnt  in  1  synchronous clear of all counters
- left_done  out  1  one-cycle pulse: left sweep completed
- right_done  out  1  one-cycle pulse: right sweep completed
- haz_done  out  1  one-cycle pulse: hazard frame completed
- seq_abort  out  1  one-cycle pulse: a left/right sweep was pre-empted by hazard
- err  out  1  one-cycle pulse: protocol error detected
- err_code  out  2  01 illegal pattern, 10 illegal transition, 11 hold overflow; holds last code until next err
- busy  out  1  decoder is in any state other than S_OFF
- left_cnt, right_cnt, haz_cnt  out  CNT_W each  saturating completion counts

Behaviour:
- Reset: state S_OFF, hold counter 0, all pulses 0, err_code 00, busy 0, all counters 0.
- Legal patterns as {l,r}:
  - OFF 000/000
  - L1 001/000, L2 011/000, L3 111/000
  - R1 000/001, R2 000/011, R3 000/111
  - BOTH 111/111
  - Any other value is an illegal pattern.
- States: S_OFF, S_L1, S_L2, S_L3, S_R1, S_R2, S_R3, S_BOTH, S_RESYNC. The state equals the last accepted pattern.
- Legal transitions on a sampled cycle:
  - S_OFF -> S_OFF, S_L1, S_R1 or S_BOTH
  - S_L1 -> S_L2; S_L2 -> S_L3; S_L3 -> S_OFF
  - S_R1 -> S_R2; S_R2 -> S_R3; S_R3 -> S_OFF
  - S_BOTH -> S_OFF
  - S_L1, S_L2, S_R1, S_R2 -> S_BOTH (hazard pre-emption): seq_abort=1.
- Completion pulses:
  - S_L3 -> OFF: left_done=1, left_cnt+1.
  - S_R3 -> OFF: right_done=1, right_cnt+1.
  - S_BOTH -> OFF: haz_done=1, haz_cnt+1.
- Hold counting:
  - Same non-OFF pattern repeated: legal while hold count < HOLD_MAX, and the hold count increments.
  - Repeat beyond HOLD_MAX: err, code 11.
  - Hold count clears on any state change.
- Errors:
  - Illegal pattern takes priority (code 01) over illegal transition (code 10).
  - On any error: err=1, no done pulse, no count, state -> S_RESYNC.
- S_RESYNC: stays until an OFF sample, then -> S_OFF. Non-OFF samples here raise no further err.
- Latency: all outputs are registered and appear in the cycle after the sampling edge. Pulses last exactly one cycle.
- sample_en=0: no state change, hold count frozen, all pulses 0.
- Counters:
  - Saturate at 2^CNT_W-1 with no wrap.
  - clr_cnt zeroes all three counters next cycle.
  - clr_cnt coinciding with an increment: clear wins (count reads 0). Pulses are unaffected by clr_cnt.
- Reset mid-sequence: immediate return to reset values. The next sample is judged from S_OFF.

Test Plan:
- Left sweep: OFF, L1, L2, L3, OFF with sample_en=1 -> left_done pulses 1 cycle after the final OFF; left_cnt=1; err never set; busy high for 3 cycles.
- Hazard pre-empt: OFF, R1, R2, BOTH, OFF -> seq_abort after BOTH; haz_done after OFF; haz_cnt=1; right_cnt=0.
- Illegal pattern: OFF, {010,000} -> err=1, err_code=01, state S_RESYNC. Then L2, OFF -> no err. Then L1, L2, L3, OFF -> left_done.
- Hold: HOLD_MAX=1, OFF, L1, L1, L2, L2, L2 -> err code 11 on the third L2 only. With HOLD_MAX=0, OFF, L1, L1 -> err code 11.
- Illegal transition: OFF, L1, L3 -> err_code=10. Also sample_en low between L1 and L2 for 5 cycles -> no error, left_done still issued.
- Saturation/clear: CNT_W=2, five left sweeps -> left_cnt=3. Then clr_cnt coinciding with a sixth completion -> left_cnt=0 and left_done=1. Async rst_b low mid-sweep -> all outputs 0 immediately.
